vector_sequencer: RTL and testbench
===================================

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- OUT_WIDTH, 8, coordinate width.
- ADR_WIDTH, 16, vector RAM address width.
- DATAWIDTH, 18, vector entry width {x, y, line, pos}.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- draw_frame, in, 1, list-ready level from the list builder.
- frame_done, out, 1, one-cycle pulse: list fully drawn.
- adrREAD, out, ADR_WIDTH, vector RAM read address (registered).
- dataREAD, in, DATAWIDTH, RAM data; valid the cycle after adrREAD is presented.
- line_start, out, 1, one-cycle pulse to the line drawer.
- x0, y0, x1, y1, out, OUT_WIDTH each, line endpoints; stable from line_start until line_done.
- line_done, in, 1, one-cycle pulse from the line drawer.
- overrun, out, 1, sticky flag: address wrapped without an end marker.
- state_debug, out, 3, current state encoding.

Function
REQ-003 Entry decode: x=dataREAD[17:10], y=dataREAD[9:2], line=dataREAD[1], pos=dataREAD[0].
REQ-004 Entry types:
- {line,pos}=01: MOVE; set the current point to (x,y); no draw.
- 10: LINE; draw from the current point to (x,y); the current point then becomes (x,y).
- 11: END of list.
- 00: NOP; skipped.
REQ-005 States and encodings: IDLE=0, FETCH=1, WAIT_DATA=2, DECODE=3, DRAW=4, WAIT_LINE=5, FINISH=6.
REQ-006 IDLE: set adrREAD=0; on a draw_frame rising edge (draw_frame=1, previous-cycle sample=0), go to FETCH. A level held high does not restart.
REQ-007 FETCH: present adrREAD, then go to WAIT_DATA.
REQ-008 WAIT_DATA: one-cycle RAM latency, then go to DECODE.
REQ-009 DECODE transitions:
- MOVE: load the current point, increment adrREAD, go to FETCH.
- NOP: increment adrREAD, go to FETCH.
- LINE: load x0,y0 from the current point and x1,y1 from the entry, go to DRAW.
- END: go to FINISH.
REQ-010 DRAW: assert line_start for exactly one cycle, then go to WAIT_LINE.
REQ-011 WAIT_LINE: on line_done, set the current point to (x1,y1), increment adrREAD, go to FETCH. Otherwise hold with no timeout.
REQ-012 FINISH: pulse frame_done for one cycle, reset adrREAD to 0, go to IDLE.
REQ-013 Throughput: MOVE/NOP entries take 3 cycles each. A LINE entry takes 5 cycles plus drawer time.
REQ-014 After reset, the current point is (0,0). A LINE before any MOVE draws from (0,0).
REQ-015 Degenerate lines (x0==x1 and y0==y1) are still issued with line_start.
REQ-016 Overrun: if DECODE would increment adrREAD from 2^ADR_WIDTH-1, do not wrap. Set overrun=1 and go to FINISH. overrun clears only on reset.
REQ-017 line_done outside WAIT_LINE is ignored.
REQ-018 A draw_frame rising edge in any state other than IDLE is ignored, not queued. The edge-detect register keeps tracking, so a level still high after FINISH does not retrigger.
REQ-019 If frame_done and a new draw_frame rising edge occur in the same cycle, the edge is ignored.
REQ-020 All outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-021 rst_n=0 forces immediately, regardless of clk:
- state=IDLE
- adrREAD=0
- line_start=0, frame_done=0, overrun=0
- x0=y0=x1=y1=0, current point=(0,0)
- draw_frame edge register=0
REQ-022 Reset asserted mid-line drops line_start and abandons the frame; no frame_done is issued.
REQ-023 After rst_n deasserts, a frame starts only on a new draw_frame rising edge. draw_frame already high at release counts as an edge, because the edge register reset to 0.

Verification
REQ-024 RAM [0]={10,20,01}, [1]={50,60,10}, [2]={0,0,11}; pulse draw_frame; drawer answers line_done 3 cycles after line_start -> exactly one line_start with (10,20)->(50,60), then one frame_done; adrREAD returns to 0.
REQ-025 RAM [0]={5,5,01}, [1]={9,5,10}, [2]={9,9,10}, [3]=11 -> two lines, (5,5)->(9,5) then (9,5)->(9,9); the second line_start occurs only after the first line_done.
REQ-026 Hold draw_frame high for 100 cycles over a 2-entry list -> exactly one frame_done; the sequencer stays in IDLE afterwards.
REQ-027 Stray line_done pulses in IDLE and FETCH, and a draw_frame edge during WAIT_LINE -> no state change, no extra line_start, no extra frame.
REQ-028 Small ADR_WIDTH=4 with RAM all 00 -> after address 15 decodes: overrun=1, one frame_done, IDLE.
REQ-029 Assert rst_n=0 during WAIT_LINE -> all outputs at reset values within the same cycle; no frame_done afterwards.

Source files
------------

// File: rtl/vector_sequencer.sv
// Vector list sequencer: walks a RAM of {x, y, line, pos} entries and hands
// each LINE segment to an external line drawer, pulsing frame_done at END.
module vector_sequencer #(
  parameter int OUT_WIDTH = 8,
  parameter int ADR_WIDTH = 16,
  parameter int DATAWIDTH = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 draw_frame,
  output logic                 frame_done,
  output logic [ADR_WIDTH-1:0] adrREAD,
  input  logic [DATAWIDTH-1:0] dataREAD,
  output logic                 line_start,
  output logic [OUT_WIDTH-1:0] x0,
  output logic [OUT_WIDTH-1:0] y0,
  output logic [OUT_WIDTH-1:0] x1,
  output logic [OUT_WIDTH-1:0] y1,
  input  logic                 line_done,
  output logic                 overrun,
  output logic [2:0]           state_debug
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_DATA = 3'd2,
    DECODE    = 3'd3,
    DRAW      = 3'd4,
    WAIT_LINE = 3'd5,
    FINISH    = 3'd6
  } state_t;

  state_t                 state_q;
  logic [ADR_WIDTH-1:0]   adr_q;
  logic                   lineStart_q;
  logic                   frameDone_q;
  logic                   overrun_q;
  logic                   drawPrev_q;
  logic [OUT_WIDTH-1:0]   x0_q, y0_q, x1_q, y1_q;
  logic [OUT_WIDTH-1:0]   curX_q, curY_q;

  logic [OUT_WIDTH-1:0]   entX_d, entY_d;
  logic [1:0]             entType_d;
  logic [ADR_WIDTH-1:0]   adrInc_d;
  logic                   adrLast_d;
  logic                   frameStart_d;

  assign entX_d    = dataREAD[DATAWIDTH-1 -: OUT_WIDTH];
  assign entY_d    = dataREAD[2 +: OUT_WIDTH];
  assign entType_d = dataREAD[1:0];
  assign adrInc_d  = adr_q + ADR_WIDTH'(1);
  assign adrLast_d = &adr_q;
  // A frame_done cycle swallows a coincident start edge.
  assign frameStart_d = draw_frame && !drawPrev_q && !frameDone_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      lineStart_q <= 1'b0;
      frameDone_q <= 1'b0;
      overrun_q   <= 1'b0;
      drawPrev_q  <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      curX_q      <= '0;
      curY_q      <= '0;
    end else begin
      drawPrev_q  <= draw_frame;
      lineStart_q <= 1'b0;
      frameDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          adr_q <= '0;
          if (frameStart_d) state_q <= FETCH;
        end
        FETCH:     state_q <= WAIT_DATA;
        WAIT_DATA: state_q <= DECODE;
        DECODE: begin
          case (entType_d)
            2'b11: state_q <= FINISH;
            2'b10: begin
              x0_q    <= curX_q;
              y0_q    <= curY_q;
              x1_q    <= entX_d;
              y1_q    <= entY_d;
              state_q <= DRAW;
            end
            default: begin
              if (entType_d == 2'b01) begin
                curX_q <= entX_d;
                curY_q <= entY_d;
              end
              // Running off the top of the address space ends the frame.
              if (adrLast_d) begin
                overrun_q <= 1'b1;
                state_q   <= FINISH;
              end else begin
                adr_q   <= adrInc_d;
                state_q <= FETCH;
              end
            end
          endcase
        end
        DRAW: begin
          lineStart_q <= 1'b1;
          state_q     <= WAIT_LINE;
        end
        WAIT_LINE: begin
          if (line_done) begin
            curX_q <= x1_q;
            curY_q <= y1_q;
            if (adrLast_d) begin
              overrun_q <= 1'b1;
              state_q   <= FINISH;
            end else begin
              adr_q   <= adrInc_d;
              state_q <= FETCH;
            end
          end
        end
        FINISH: begin
          frameDone_q <= 1'b1;
          adr_q       <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_done  = frameDone_q;
  assign adrREAD     = adr_q;
  assign line_start  = lineStart_q;
  assign x0          = x0_q;
  assign y0          = y0_q;
  assign x1          = x1_q;
  assign y1          = y1_q;
  assign overrun     = overrun_q;
  assign state_debug = state_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: a registered RAM model, an optional
// auto-responding line drawer, and a small-address instance for overrun.
module tb_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        drawFrame;
  logic        frameDone;
  logic [15:0] adrRead;
  logic [17:0] dataRead;
  logic        lineStart;
  logic [7:0]  x0, y0, x1, y1;
  logic        lineDone;
  logic        overrun;
  logic [2:0]  stateDbg;

  logic        drawSmall;
  logic        frameDoneSmall;
  logic [3:0]  adrSmall;
  logic [17:0] dataSmall;
  logic        lineStartSmall;
  logic [7:0]  sx0, sy0, sx1, sy1;
  logic        lineDoneSmall;
  logic        overrunSmall;
  logic [2:0]  stateSmall;

  logic [17:0] ram [0:15];
  logic        drawerEn;
  logic        lineDoneAuto = 1'b0;
  logic        lineDoneMan;
  int          drawCnt = 0;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          lineStarts = 0;
  int          lineDones = 0;
  int          frames = 0;
  int          framesSmall = 0;
  logic [31:0] recLine [0:15];
  int          recDones [0:15];

  vector_sequencer dut (
    .clk(clk), .rst_n(rst_n), .draw_frame(drawFrame), .frame_done(frameDone),
    .adrREAD(adrRead), .dataREAD(dataRead), .line_start(lineStart),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .line_done(lineDone),
    .overrun(overrun), .state_debug(stateDbg)
  );

  vector_sequencer #(.ADR_WIDTH(4)) dutSmall (
    .clk(clk), .rst_n(rst_n), .draw_frame(drawSmall), .frame_done(frameDoneSmall),
    .adrREAD(adrSmall), .dataREAD(dataSmall), .line_start(lineStartSmall),
    .x0(sx0), .y0(sy0), .x1(sx1), .y1(sy1), .line_done(lineDoneSmall),
    .overrun(overrunSmall), .state_debug(stateSmall)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) dataRead <= (adrRead < 16'd16) ? ram[adrRead[3:0]] : 18'd0;

  // Drawer model: answers each line_start a few cycles later when enabled.
  always @(posedge clk) begin
    lineDoneAuto <= 1'b0;
    if (drawCnt == 1) begin
      lineDoneAuto <= 1'b1;
      drawCnt <= 0;
    end else if (drawCnt > 1) drawCnt <= drawCnt - 1;
    else if (drawerEn && lineStart) drawCnt <= 3;
  end
  assign lineDone = lineDoneAuto | lineDoneMan;

  always @(posedge clk) begin
    if (lineStart === 1'b1) begin
      if (lineStarts < 16) begin
        recLine[lineStarts] = {x0, y0, x1, y1};
        recDones[lineStarts] = lineDones;
      end
      lineStarts++;
    end
    if (lineDone === 1'b1) lineDones++;
    if (frameDone === 1'b1) frames++;
    if (frameDoneSmall === 1'b1) framesSmall++;
  end

  function automatic logic [17:0] ent(input int x, input int y, input int t);
    return {x[7:0], y[7:0], t[1:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus();
    drawFrame = 1'b1;
    @(negedge clk);
    drawFrame = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && frames < target; i++) @(negedge clk);
    checkOutput(tag, frames, target);
  endtask

  task automatic waitState(input logic [2:0] s, input int budget, input string tag);
    for (int i = 0; i < budget && stateDbg !== s; i++) @(negedge clk);
    checkOutput(tag, stateDbg, s);
  endtask

  initial begin
    int base;
    int doneBase;
    rst_n = 1'b0; drawFrame = 1'b0; lineDoneMan = 1'b0; drawerEn = 1'b1;
    drawSmall = 1'b0; dataSmall = 18'd0; lineDoneSmall = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 18'd0;

    @(negedge clk);
    checkOutput("rst state", stateDbg, 0);
    checkOutput("rst adr", adrRead, 0);
    checkOutput("rst pulses", {lineStart, frameDone, overrun}, 0);
    checkOutput("rst coords", {x0, y0, x1, y1}, 0);
    checkOutput("rst small overrun", overrunSmall, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    checkOutput("idle after release", stateDbg, 0);

    lineDoneMan = 1'b1; tick(1); lineDoneMan = 1'b0; tick(1);
    checkOutput("stray done idle state", stateDbg, 0);
    checkOutput("stray done idle starts", lineStarts, 0);

    // Single MOVE + LINE + END with per-cycle state tracking.
    ram[0] = ent(10, 20, 1); ram[1] = ent(50, 60, 2); ram[2] = ent(0, 0, 3);
    applyStimulus();
    checkOutput("t1 fetch", stateDbg, 1);
    tick(1); checkOutput("t1 wait", stateDbg, 2);
    tick(1); checkOutput("t1 decode", stateDbg, 3);
    tick(1); checkOutput("t1 move next", {adrRead, 13'd0, stateDbg}, {16'd1, 13'd0, 3'd1});
    tick(2); checkOutput("t1 decode line", stateDbg, 3);
    tick(1); checkOutput("t1 draw", stateDbg, 4);
    tick(1); checkOutput("t1 line_start", {lineStart, stateDbg}, {1'b1, 3'd5});
    checkOutput("t1 endpoints", {x0, y0, x1, y1}, {8'd10, 8'd20, 8'd50, 8'd60});
    waitFrames(1, 50, "t1 frame");
    checkOutput("t1 line count", lineStarts, 1);
    checkOutput("t1 adr back", adrRead, 0);
    checkOutput("t1 idle", stateDbg, 0);

    // Two chained lines; the second starts from the first's end.
    ram[0] = ent(5, 5, 1); ram[1] = ent(9, 5, 2); ram[2] = ent(9, 9, 2); ram[3] = ent(0, 0, 3);
    base = lineStarts; doneBase = lineDones;
    applyStimulus();
    waitFrames(2, 100, "t2 frame");
    checkOutput("t2 line count", lineStarts, base + 2);
    checkOutput("t2 line a", recLine[base], {8'd5, 8'd5, 8'd9, 8'd5});
    checkOutput("t2 line b", recLine[base + 1], {8'd9, 8'd5, 8'd9, 8'd9});
    checkOutput("t2 order a", recDones[base], doneBase);
    checkOutput("t2 order b", recDones[base + 1], doneBase + 1);

    // Level held high runs exactly one frame.
    ram[0] = ent(3, 4, 1); ram[1] = ent(0, 0, 3);
    drawFrame = 1'b1;
    tick(100);
    checkOutput("t3 one frame", frames, 3);
    checkOutput("t3 idle", stateDbg, 0);
    drawFrame = 1'b0;
    tick(5);
    checkOutput("t3 no retrigger", frames, 3);

    // Stray line_done in FETCH, start edge during WAIT_LINE.
    ram[0] = ent(10, 20, 1); ram[1] = ent(50, 60, 2); ram[2] = ent(0, 0, 3);
    drawerEn = 1'b0;
    applyStimulus();
    lineDoneMan = 1'b1; tick(1); lineDoneMan = 1'b0;
    checkOutput("t4 stray done fetch", stateDbg, 2);
    waitState(3'd5, 20, "t4 reach wait_line");
    drawFrame = 1'b1; tick(1); drawFrame = 1'b0; tick(5);
    checkOutput("t4 hold wait_line", stateDbg, 5);
    checkOutput("t4 single start", lineStarts, 4);
    lineDoneMan = 1'b1; tick(1); lineDoneMan = 1'b0;
    waitFrames(4, 50, "t4 frame");
    tick(20);
    checkOutput("t4 no queued frame", {frames[7:0], lineStarts[7:0], 5'd0, stateDbg}, {8'd4, 8'd4, 8'd0});

    // Reset mid-line.
    applyStimulus();
    waitState(3'd5, 20, "t5 reach wait_line");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5 async state", stateDbg, 0);
    checkOutput("t5 async outs", {lineStart, frameDone, overrun, adrRead}, 0);
    checkOutput("t5 async coords", {x0, y0, x1, y1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(10);
    checkOutput("t5 no frame_done", frames, 4);
    rst_n = 1'b0; drawFrame = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checkOutput("t5 high at release starts", stateDbg, 1);
    drawerEn = 1'b1;
    waitFrames(5, 60, "t5 frame after release");
    drawFrame = 1'b0;

    // Overrun on the 4-bit address instance with an all-NOP RAM.
    checkOutput("t6 overrun clear", overrunSmall, 0);
    drawSmall = 1'b1; tick(1); drawSmall = 1'b0;
    for (int i = 0; i < 100 && framesSmall < 1; i++) @(negedge clk);
    checkOutput("t6 frame", framesSmall, 1);
    checkOutput("t6 overrun", overrunSmall, 1);
    checkOutput("t6 idle", {stateSmall, adrSmall}, 0);
    tick(10);
    checkOutput("t6 sticky", {overrunSmall, framesSmall[7:0]}, {1'b1, 8'd1});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
